// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared constants and types for the bus_decoder block: default bus widths,
// the default region table, read-tracker geometry and the tracker entry type.
// No ports (package).
// ---------------------------------------------------------------------------
package bus_pkg;

    localparam int DEF_NUM_REGIONS = 4;
    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DATA_W      = 8;

    // Deepest supported read latency; the tracker has one stage per cycle.
    localparam int LAT_MAX = 3;
    localparam int LAT_W   = 2;

    // Region index width leaves room for up to 8 regions plus the marker.
    localparam int                IDX_W    = 4;
    // Tracker marker for reads that return zeros (unmapped or write-only).
    localparam logic [IDX_W-1:0]  ZERO_IDX = 4'hF;

    localparam logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_BASE =
        {16'h2000, 16'h1000, 16'h0000, 16'h0000};
    localparam logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_LIMIT =
        {16'h2960, 16'h10FF, 16'h07FF, 16'h0000};
    localparam logic [DEF_NUM_REGIONS*LAT_W-1:0] DEF_REGION_LAT =
        {2'd0, 2'd1, 2'd1, 2'd1};

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } trk_entry_t;

    // Inclusive range test. A region with lo > hi can never match.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/bus_decoder_if.sv
// ---------------------------------------------------------------------------
// bus_decoder_if
// Bundle of the CPU data-port, target-side and fault signals of bus_decoder.
//   master : CPU/target side (drives requests, target read data, fault_clr)
//   slave  : the decoder (drives ready/rdata/rvalid, enables, fault state)
// ---------------------------------------------------------------------------
interface bus_decoder_if
    import bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_REGIONS = DEF_NUM_REGIONS
);
    logic [ADDR_W-1:0]             m_addr;
    logic [DATA_W-1:0]             m_wdata;
    logic                          m_we;
    logic                          m_re;
    logic                          m_ready;
    logic [DATA_W-1:0]             m_rdata;
    logic                          m_rvalid;
    logic [NUM_REGIONS-1:0]        t_we;
    logic [NUM_REGIONS-1:0]        t_re;
    logic [ADDR_W-1:0]             t_addr;
    logic [DATA_W-1:0]             t_wdata;
    logic [NUM_REGIONS*DATA_W-1:0] t_rdata;
    logic                          fault;
    logic [ADDR_W-1:0]             fault_addr;
    logic                          fault_we;
    logic                          fault_clr;

    modport master (
        output m_addr, m_wdata, m_we, m_re, t_rdata, fault_clr,
        input  m_ready, m_rdata, m_rvalid, t_we, t_re, t_addr, t_wdata,
               fault, fault_addr, fault_we
    );

    modport slave (
        input  m_addr, m_wdata, m_we, m_re, t_rdata, fault_clr,
        output m_ready, m_rdata, m_rvalid, t_we, t_re, t_addr, t_wdata,
               fault, fault_addr, fault_we
    );

endinterface

// File: rtl/bus_decoder_read_tracker.sv
// ---------------------------------------------------------------------------
// read_tracker
// In-order read-return pipeline. An accepted read of latency L is placed in
// stage L-1 and shifts toward stage 0 once per cycle; stage 0 produces the
// rvalid pulse and selects the returning target's data.
// Ports:
//   clk, rst      : clock, async active-high reset (drops outstanding reads)
//   i_push        : read accepted this cycle
//   i_push_lat    : effective latency of the accepted read (1..LAT_MAX)
//   i_push_idx    : region index, or ZERO_IDX for a zero-returning read
//   i_req_lat     : effective latency of the read currently requested
//   i_t_rdata     : packed per-target read data
//   o_stall       : the requested read would overtake an outstanding one
//   o_rvalid      : read data valid this cycle
//   o_rdata       : read data (zero when not valid)
// ---------------------------------------------------------------------------
module read_tracker
    import bus_pkg::*;
#(
    parameter int NUM_REGIONS = DEF_NUM_REGIONS,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [LAT_W-1:0]              i_push_lat,
    input  logic [IDX_W-1:0]              i_push_idx,
    input  logic [LAT_W-1:0]              i_req_lat,
    input  logic [NUM_REGIONS*DATA_W-1:0] i_t_rdata,
    output logic                          o_stall,
    output logic                          o_rvalid,
    output logic [DATA_W-1:0]             o_rdata
);

    trk_entry_t [LAT_MAX-1:0] r_stage;
    logic                     w_stall;
    logic [DATA_W-1:0]        w_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            for (int k = 0; k < LAT_MAX - 1; k++) begin
                r_stage[k] <= r_stage[k+1];
            end
            r_stage[LAT_MAX-1] <= '0;
            // The stall rule guarantees the target stage is vacated by the
            // shift, so the new entry never collides with an old one.
            for (int k = 0; k < LAT_MAX; k++) begin
                if (i_push && (i_push_lat == LAT_W'(k + 1))) begin
                    r_stage[k] <= trk_entry_t'{valid: 1'b1, idx: i_push_idx};
                end
            end
        end
    end

    // An entry in stage k returns k cycles from now; a new read of latency L
    // returns L cycles from now, so any entry with k >= L would be overtaken.
    always_comb begin
        w_stall = 1'b0;
        for (int k = 1; k < LAT_MAX; k++) begin
            if (r_stage[k].valid && (LAT_W'(k) >= i_req_lat)) begin
                w_stall = 1'b1;
            end
        end
    end

    // ZERO_IDX never matches a real region, so those reads return zeros.
    always_comb begin
        w_rdata = '0;
        if (r_stage[0].valid) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (r_stage[0].idx == IDX_W'(i)) begin
                    w_rdata = i_t_rdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign o_stall  = w_stall;
    assign o_rvalid = r_stage[0].valid;
    assign o_rdata  = w_rdata;

endmodule

// File: rtl/bus_decoder.sv
// ---------------------------------------------------------------------------
// bus_decoder
// Memory-map decoder between the CPU data port and NUM_REGIONS targets.
// Priority-ordered region table (lowest index wins), per-region read latency
// with in-order return and stall, and sticky capture of the first unmapped
// access.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : bus_decoder_if.slave -- CPU request/response, target enables,
//          address/data passthrough, target read data, fault state/clear
// ---------------------------------------------------------------------------
module bus_decoder
    import bus_pkg::*;
#(
    parameter int                            NUM_REGIONS  = DEF_NUM_REGIONS,
    parameter int                            ADDR_W       = DEF_ADDR_W,
    parameter int                            DATA_W       = DEF_DATA_W,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = DEF_REGION_LIMIT,
    parameter logic [NUM_REGIONS*LAT_W-1:0]  REGION_LAT   = DEF_REGION_LAT
) (
    input logic          clk,
    input logic          rst,
    bus_decoder_if.slave bus
);

    logic                   w_hit;
    logic [IDX_W-1:0]       w_hit_idx;
    logic [LAT_W-1:0]       w_hit_lat;
    logic                   w_wr_req;
    logic                   w_rd_req;
    logic                   w_rd_zero;
    logic [LAT_W-1:0]       w_req_lat;
    logic                   w_stall;
    logic                   w_ready;
    logic                   w_rd_accept;
    logic [IDX_W-1:0]       w_push_idx;
    logic [NUM_REGIONS-1:0] w_onehot;
    logic                   w_fault_ev;
    logic                   w_rvalid;
    logic [DATA_W-1:0]      w_rdata;

    logic                   r_fault;
    logic [ADDR_W-1:0]      r_fault_addr;
    logic                   r_fault_we;

    // Scan from the top so the lowest-index hit is the one that sticks.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_hit_lat = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (in_range(32'(bus.m_addr),
                         32'(REGION_BASE[i*ADDR_W +: ADDR_W]),
                         32'(REGION_LIMIT[i*ADDR_W +: ADDR_W]))) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
                w_hit_lat = REGION_LAT[i*LAT_W +: LAT_W];
            end
        end
    end

    // Write has priority when both strobes are high.
    assign w_wr_req = bus.m_we;
    assign w_rd_req = bus.m_re & ~bus.m_we;

    // Unmapped and write-only reads still return (zeros) one cycle later.
    assign w_rd_zero  = !w_hit || (w_hit_lat == '0);
    assign w_req_lat  = w_rd_zero ? LAT_W'(1) : w_hit_lat;
    assign w_push_idx = w_rd_zero ? ZERO_IDX : w_hit_idx;

    assign w_ready     = !(w_rd_req && w_stall);
    assign w_rd_accept = w_rd_req && w_ready;
    assign w_onehot    = NUM_REGIONS'(1) << w_hit_idx;

    assign bus.t_we    = (!rst && w_wr_req && w_hit) ? w_onehot : '0;
    assign bus.t_re    = (!rst && w_rd_accept && !w_rd_zero) ? w_onehot : '0;
    assign bus.t_addr  = bus.m_addr;
    assign bus.t_wdata = bus.m_wdata;
    assign bus.m_ready = w_ready;

    read_tracker #(
        .NUM_REGIONS (NUM_REGIONS),
        .DATA_W      (DATA_W)
    ) u_read_tracker (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_rd_accept),
        .i_push_lat (w_req_lat),
        .i_push_idx (w_push_idx),
        .i_req_lat  (w_req_lat),
        .i_t_rdata  (bus.t_rdata),
        .o_stall    (w_stall),
        .o_rvalid   (w_rvalid),
        .o_rdata    (w_rdata)
    );

    assign bus.m_rvalid = w_rvalid;
    assign bus.m_rdata  = w_rdata;

    // A stalled read is not yet an access, so it cannot fault.
    assign w_fault_ev = (w_wr_req || w_rd_accept) && !w_hit;

    // A new fault in the same cycle as a clear is captured (set wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
            r_fault_we   <= 1'b0;
        end else if (w_fault_ev && (!r_fault || bus.fault_clr)) begin
            r_fault      <= 1'b1;
            r_fault_addr <= bus.m_addr;
            r_fault_we   <= w_wr_req;
        end else if (bus.fault_clr) begin
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
            r_fault_we   <= 1'b0;
        end
    end

    assign bus.fault      = r_fault;
    assign bus.fault_addr = r_fault_addr;
    assign bus.fault_we   = r_fault_we;

endmodule
